next_pc_mux: RTL and testbench



---
 rtl/next_pc_mux_pkg.sv | 14 +
 rtl/next_pc_mux_if.sv | 26 ++
 rtl/next_pc_mux_pc_reg.sv | 36 +++
 rtl/next_pc_mux.sv | 37 +++
 tb/tb_next_pc_mux.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/next_pc_mux_pkg.sv
// Shared core definitions used by the next-PC selection stage: datapath
// width, reset vector, and the encoding of the next-PC source select.
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Encoding of NextPCSrc: sequential (PC+4) or ALU-computed target.
    typedef enum logic {
        NPC_SEQ = 1'b0,
        NPC_ALU = 1'b1
    } next_pc_src_e;

endpackage : core_pkg

// File: rtl/next_pc_mux_if.sv
// Signal bundle between the PC adder/ALU side and the next-PC stage.
// There is no handshake: the select and enable are sampled directly, the
// mux outputs are combinational, and pc_q updates on the clock edge.
interface next_pc_mux_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] Sumador;
    logic [XLEN-1:0] ALURes;
    logic            NextPCSrc;
    logic            pc_en;
    logic [XLEN-1:0] MUX3Res;
    logic [XLEN-1:0] pc_q;
    logic            misaligned;

    // Driver side: supplies candidate addresses, select and load enable.
    modport master (
        output Sumador, ALURes, NextPCSrc, pc_en,
        input  MUX3Res, pc_q, misaligned
    );

    // Next-PC stage side.
    modport slave (
        input  Sumador, ALURes, NextPCSrc, pc_en,
        output MUX3Res, pc_q, misaligned
    );
endinterface : next_pc_mux_if

// File: rtl/next_pc_mux_pc_reg.sv
// Program-counter register: XLEN-wide flop with load enable and
// asynchronous active-low reset to RESET_PC.
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next value: load the new PC when enabled, otherwise hold (stall).
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = d_i;
        end
    end

    // State register; reset forces the reset vector regardless of clk/en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

endmodule : pc_reg

// File: rtl/next_pc_mux.sv
// Next-PC selection stage: picks PC+4 or the ALU target, flags targets
// that are not word aligned, and holds the chosen value in the PC register.
module next_pc_mux
    import core_pkg::*;
#(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    next_pc_mux_if.slave  bus
);

    next_pc_src_e src_sel;

    // Interpret the raw select bit as the next-PC source encoding.
    assign src_sel = next_pc_src_e'(bus.NextPCSrc);

    // Pure selection; the target is passed through untouched even when
    // misaligned so downstream logic sees exactly what the ALU produced.
    assign bus.MUX3Res = (src_sel == NPC_ALU) ? bus.ALURes : bus.Sumador;

    // Informational alignment flag on the selected target.
    assign bus.misaligned = (bus.MUX3Res[1:0] != 2'b00);

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (bus.pc_en),
        .d_i   (bus.MUX3Res),
        .q_o   (bus.pc_q)
    );

endmodule : next_pc_mux

// File: tb/tb_next_pc_mux.sv
// Directed testbench for next_pc_mux: combinational selection, alignment
// flag, PC register load/stall, and asynchronous reset behaviour.
module tb_next_pc_mux;
    import core_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    next_pc_mux_if #(.XLEN(W)) bus ();

    next_pc_mux #(
        .XLEN     (W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [W-1:0] sum, input logic [W-1:0] alu,
                         input logic sel, input logic en);
        bus.Sumador   = sum;
        bus.ALURes    = alu;
        bus.NextPCSrc = sel;
        bus.pc_en     = en;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h0, 32'h0, NPC_SEQ, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: actual=%h required=%h", bus.pc_q, 32'h0);
        end
    endtask

    task automatic test_mux_basic();
        @(negedge clk);
        drive(32'h4, 32'h8, NPC_SEQ, 1'b0);
        #1;
        checks++;
        if (bus.MUX3Res !== 32'h4) begin
            errors++;
            $display("FAIL mux_seq: actual=%h required=%h", bus.MUX3Res, 32'h4);
        end
        checks++;
        if (bus.misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_seq4: actual=%b required=0", bus.misaligned);
        end
        bus.NextPCSrc = NPC_ALU;
        #1;
        checks++;
        if (bus.MUX3Res !== 32'h8) begin
            errors++;
            $display("FAIL mux_alu: actual=%h required=%h", bus.MUX3Res, 32'h8);
        end
    endtask

    task automatic test_toggle();
        @(negedge clk);
        drive(32'hC, 32'h10, NPC_SEQ, 1'b0);
        #1;
        checks++;
        if (bus.MUX3Res !== 32'hC) begin
            errors++;
            $display("FAIL toggle_seq: actual=%h required=%h", bus.MUX3Res, 32'hC);
        end
        bus.NextPCSrc = NPC_ALU;
        #1;
        checks++;
        if (bus.MUX3Res !== 32'h10) begin
            errors++;
            $display("FAIL toggle_alu: actual=%h required=%h", bus.MUX3Res, 32'h10);
        end
        // Combinational outputs ignore reset, which is still asserted here.
        checks++;
        if (bus.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL toggle_pc_in_reset: actual=%h required=%h", bus.pc_q, 32'h0);
        end
    endtask

    task automatic test_load_and_stall();
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h4, 32'h8, NPC_ALU, 1'b1);
        #1;
        checks++;
        if (bus.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL load_before_edge: actual=%h required=%h", bus.pc_q, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.pc_q !== 32'h8) begin
            errors++;
            $display("FAIL load_one_edge: actual=%h required=%h", bus.pc_q, 32'h8);
        end
        @(negedge clk);
        drive(32'h4, 32'h20, NPC_ALU, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.pc_q !== 32'h8) begin
                errors++;
                $display("FAIL stall_hold[%0d]: actual=%h required=%h", i, bus.pc_q, 32'h8);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(32'h4, 32'h10, NPC_ALU, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.pc_q !== 32'h10) begin
            errors++;
            $display("FAIL pre_reset_load: actual=%h required=%h", bus.pc_q, 32'h10);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: actual=%h required=%h", bus.pc_q, 32'h0);
        end
        drive(32'h14, 32'h10, NPC_SEQ, 1'b1);
        #1;
        checks++;
        if (bus.MUX3Res !== 32'h14) begin
            errors++;
            $display("FAIL mux_in_reset: actual=%h required=%h", bus.MUX3Res, 32'h14);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_held: actual=%h required=%h", bus.pc_q, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pc_q !== 32'h14) begin
            errors++;
            $display("FAIL first_load_after_reset: actual=%h required=%h", bus.pc_q, 32'h14);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive(32'h4, 32'h6, NPC_ALU, 1'b0);
        #1;
        checks++;
        if (bus.misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_alu6: actual=%b required=1", bus.misaligned);
        end
        checks++;
        if (bus.MUX3Res !== 32'h6) begin
            errors++;
            $display("FAIL mux_alu6: actual=%h required=%h", bus.MUX3Res, 32'h6);
        end
        bus.NextPCSrc = NPC_SEQ;
        #1;
        checks++;
        if (bus.misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_seq4b: actual=%b required=0", bus.misaligned);
        end
        drive(32'h1001, 32'h7, NPC_SEQ, 1'b0);
        #1;
        checks++;
        if (bus.misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_seq1: actual=%b required=1", bus.misaligned);
        end
        bus.NextPCSrc = NPC_ALU;
        #1;
        checks++;
        if (bus.misaligned !== 1'b1 || bus.MUX3Res !== 32'h7) begin
            errors++;
            $display("FAIL mis_alu3: actual=%b/%h required=1/%h", bus.misaligned, bus.MUX3Res, 32'h7);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sum_v [4];
        logic [W-1:0] alu_v [4];
        logic         sel_v [4];
        logic [W-1:0] exp_v [4];
        sum_v = '{32'h18, 32'h1C, 32'h40, 32'h44};
        alu_v = '{32'h100, 32'h200, 32'h300, 32'h8000_0000};
        sel_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_v = '{32'h18, 32'h200, 32'h40, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(sum_v[i], alu_v[i], sel_v[i], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (bus.pc_q !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: actual=%h required=%h", i, bus.pc_q, exp_v[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mux_basic();
        test_toggle();
        test_load_and_stall();
        test_async_reset();
        test_misaligned();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_next_pc_mux
